// File: rtl/dma_copy.sv
// dma_copy: single-channel word DMA engine (copy / fill) with a CPU register port.
//   i_clock, i_reset (async, active-low)
//   register port : i_request, i_rw, i_address[4:2], i_wdata -> o_rdata, o_ready (1-cycle pulse)
//   bus initiator : o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata <- i_bus_ready, i_bus_rdata
//   o_interrupt   : level, DONE & IE
module dma_copy #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  output logic        o_interrupt
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, NEXT} state_t;
  state_t state;
  logic [31:0] src, dst, fillval, status, rd_val, src_inc, dst_inc;
  logic [COUNT_WIDTH-1:0] count, count_dec;
  logic done, fill, ie, abort_pending, busy, access, wr, ctrl_wr, start, unused;
  logic [2:0] sel;
  always_comb begin
    sel = i_address[4:2];
    busy = state != IDLE;
    // a request is not re-sampled in the o_ready cycle, so a held request completes every other cycle
    access = i_request && !o_ready;
    wr = access && i_rw;
    ctrl_wr = wr && sel == 3'd3;
    start = ctrl_wr && i_wdata[0] && !busy;
    src_inc = src + 32'd4;
    dst_inc = dst + 32'd4;
    count_dec = count - COUNT_WIDTH'(1);
    status = {27'd0, ie, 1'b0, fill, done, busy};
    rd_val = sel == 3'd0 ? src :
             sel == 3'd1 ? dst :
             sel == 3'd2 ? 32'(count) :
             sel == 3'd3 ? status :
             sel == 3'd4 ? fillval : 32'd0;
  end
  assign o_interrupt = done & ie;
  assign unused = ^{i_address[31:5], i_address[1:0]};
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      fillval <= '0;
      count <= '0;
      done <= 1'b0;
      fill <= 1'b0;
      ie <= 1'b0;
      abort_pending <= 1'b0;
      o_ready <= 1'b0;
      o_rdata <= '0;
      o_bus_request <= 1'b0;
      o_bus_rw <= 1'b0;
      o_bus_address <= '0;
      o_bus_wdata <= '0;
    end else begin
      o_ready <= access;
      if (access && !i_rw) o_rdata <= rd_val;
      if (wr && !busy && sel == 3'd0) src <= {i_wdata[31:2], 2'b00};
      if (wr && !busy && sel == 3'd1) dst <= {i_wdata[31:2], 2'b00};
      if (wr && !busy && sel == 3'd2) count <= i_wdata[COUNT_WIDTH-1:0];
      if (wr && !busy && sel == 3'd4) fillval <= i_wdata;
      if (ctrl_wr) begin
        ie <= i_wdata[4];
        if (i_wdata[3]) done <= 1'b0;
        if (busy && i_wdata[2]) abort_pending <= 1'b1;
      end
      // later assignments to done below override a same-cycle clear, so a DONE set wins
      if (start) begin
        done <= count == '0;
        fill <= i_wdata[1];
      end
      if (start && count != '0) begin
        state <= i_wdata[1] ? WRITE : READ;
        o_bus_request <= 1'b1;
        o_bus_rw <= i_wdata[1];
        o_bus_address <= i_wdata[1] ? dst : src;
        o_bus_wdata <= fillval;
      end
      // o_bus_wdata doubles as the data register between the read and write beats
      if (state == READ && i_bus_ready) begin
        state <= WRITE;
        o_bus_rw <= 1'b1;
        o_bus_address <= dst;
        o_bus_wdata <= i_bus_rdata;
      end
      if (state == WRITE && i_bus_ready) begin
        state <= NEXT;
        o_bus_request <= 1'b0;
        o_bus_rw <= 1'b0;
      end
      if (state == NEXT) begin
        count <= count_dec;
        dst <= dst_inc;
        if (!fill) src <= src_inc;
        if (count_dec == '0 || abort_pending) begin
          state <= IDLE;
          done <= 1'b1;
          abort_pending <= 1'b0;
        end else begin
          state <= fill ? WRITE : READ;
          o_bus_request <= 1'b1;
          o_bus_rw <= fill;
          o_bus_address <= fill ? dst_inc : src_inc;
        end
      end
    end
  end
endmodule
